// File: rtl/cruise_sched_if.sv
// rtl/cruise_sched_if.sv - target-speed load channel between driver controls and cruise_sched
interface cruise_sched_if;
    logic       set_valid;
    logic [7:0] set_speed;
    logic       set_ready;

    modport master (
        output set_valid,
        output set_speed,
        input  set_ready
    );

    modport slave (
        input  set_valid,
        input  set_speed,
        output set_ready
    );
endinterface

// File: rtl/cruise_sched.sv
// rtl/cruise_sched.sv - ramp-limited accelerator/brake command scheduler for cruise control
// Optional watchdog on stuck ACCEL/BRAKE enabled by defining CRUISE_WDT_EN.
module cruise_sched #(
    parameter int STEP        = 10,
    parameter int HYST        = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int AF_MAX      = 200,
    parameter int BF_MAX      = 200,
    parameter int WDT_CYCLES  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        speed,
    cruise_sched_if.slave     set,
    input  logic              cancel,
    input  logic              drv_brake,
    input  logic [7:0]        drv_bf,
    output logic [7:0]        af,
    output logic [7:0]        bf,
    output logic [1:0]        state,
    output logic              engaged,
    output logic              at_speed,
    output logic [7:0]        target,
    output logic              fault
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        BRAKE  = 2'd3
    } state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("WDT_CYCLES must be at least 1");
    end

    state_t        state_q, state_d;
    logic [7:0]    af_d, bf_d, target_d;
    logic          at_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          set_ok;

    function automatic logic [7:0] lo_of(input logic [7:0] t);
        lo_of = (t >= 8'(HYST)) ? t - 8'(HYST) : 8'd0;
    endfunction

    function automatic logic [7:0] hi_of(input logic [7:0] t);
        logic [8:0] s;
        s = {1'b0, t} + 9'(HYST);
        hi_of = (s > 9'd255) ? 8'hFF : s[7:0];
    endfunction

    function automatic state_t band(input logic [7:0] t, input logic [7:0] spd);
        if (spd < lo_of(t))      band = ACCEL;
        else if (spd > hi_of(t)) band = BRAKE;
        else                     band = CRUISE;
    endfunction

    // Sum is 9 bits wide so the ceiling clamps instead of the command wrapping.
    function automatic logic [7:0] ramp(input logic [7:0] v, input int mx);
        logic [8:0] s;
        s = {1'b0, v} + 9'(STEP);
        ramp = (s > 9'(mx)) ? 8'(mx) : s[7:0];
    endfunction

    assign set.set_ready = !drv_brake && !cancel;
    assign set_ok        = set.set_valid && set.set_ready;
    assign state         = state_q;
    assign engaged       = (state_q != IDLE);

`ifdef CRUISE_WDT_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] wdt_q, wdt_d;
    logic          fault_q, fault_d;
    logic          trip;

    assign trip  = (state_q == ACCEL || state_q == BRAKE) && (wdt_q == WW'(WDT_CYCLES - 1));
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        af_d     = af;
        bf_d     = bf;
        target_d = target;
        at_d     = at_speed;
        hold_d   = hold_q;
`ifdef CRUISE_WDT_EN
        fault_d  = 1'b0;
`endif
        if (drv_brake) begin
            state_d = IDLE;
            af_d    = 8'd0;
            bf_d    = drv_bf;
            at_d    = 1'b0;
            hold_d  = '0;
        end else if (cancel) begin
            state_d = IDLE;
            af_d    = 8'd0;
            bf_d    = 8'd0;
            at_d    = 1'b0;
            hold_d  = '0;
        end else if (set_ok) begin
            // Band is judged against the incoming target, not the old one.
            target_d = set.set_speed;
            state_d  = band(set.set_speed, speed);
            af_d     = 8'd0;
            bf_d     = 8'd0;
            at_d     = 1'b0;
            hold_d   = '0;
`ifdef CRUISE_WDT_EN
        end else if (trip) begin
            state_d = IDLE;
            af_d    = 8'd0;
            bf_d    = 8'd0;
            at_d    = 1'b0;
            hold_d  = '0;
            fault_d = 1'b1;
`endif
        end else begin
            case (state_q)
                ACCEL: begin
                    bf_d   = 8'd0;
                    at_d   = 1'b0;
                    hold_d = '0;
                    if (speed >= lo_of(target)) begin
                        state_d = CRUISE;
                        af_d    = 8'd0;
                    end else begin
                        af_d = ramp(af, AF_MAX);
                    end
                end
                BRAKE: begin
                    af_d   = 8'd0;
                    at_d   = 1'b0;
                    hold_d = '0;
                    if (speed <= hi_of(target)) begin
                        state_d = CRUISE;
                        bf_d    = 8'd0;
                    end else begin
                        bf_d = ramp(bf, BF_MAX);
                    end
                end
                CRUISE: begin
                    af_d = 8'd0;
                    bf_d = 8'd0;
                    if (band(target, speed) == CRUISE) begin
                        if (hold_q != HW'(HOLD_CYCLES)) hold_d = hold_q + 1'b1;
                        at_d = (hold_d == HW'(HOLD_CYCLES));
                    end else begin
                        state_d = band(target, speed);
                        hold_d  = '0;
                        at_d    = 1'b0;
                    end
                end
                default: begin
                    af_d   = 8'd0;
                    bf_d   = 8'd0;
                    at_d   = 1'b0;
                    hold_d = '0;
                end
            endcase
        end
    end

`ifdef CRUISE_WDT_EN
    always_comb begin
        wdt_d = '0;
        if ((state_q == ACCEL || state_q == BRAKE) &&
            (state_d == ACCEL || state_d == BRAKE) && !set_ok && !trip)
            wdt_d = wdt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            fault_q <= fault_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            af       <= 8'd0;
            bf       <= 8'd0;
            target   <= 8'd0;
            at_speed <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            af       <= af_d;
            bf       <= bf_d;
            target   <= target_d;
            at_speed <= at_d;
            hold_q   <= hold_d;
        end
    end
endmodule

// File: tb/tb_cruise_sched.sv
// tb/tb_cruise_sched.sv - scoreboard bench for cruise_sched with directed vectors
module tb_cruise_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] speed;
    logic       cancel;
    logic       drv_brake;
    logic [7:0] drv_bf;
    logic [7:0] af, bf, target;
    logic [1:0] state;
    logic       engaged, at_speed, fault;

    cruise_sched_if sif ();

    cruise_sched dut (
        .clk       (clk),
        .rst       (rst),
        .speed     (speed),
        .set       (sif.slave),
        .cancel    (cancel),
        .drv_brake (drv_brake),
        .drv_bf    (drv_bf),
        .af        (af),
        .bf        (bf),
        .state     (state),
        .engaged   (engaged),
        .at_speed  (at_speed),
        .target    (target),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [7:0] af;
        logic [7:0] bf;
        logic [7:0] tgt;
        logic       at;
        logic       flt;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string t, input string f, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s got %0d expected %0d", t, f, act, exp);
        end
    endtask

    // Expected values describe the outputs after the coming rising edge.
    task automatic tick(input string tag, input logic [1:0] st, input logic [7:0] eaf,
                        input logic [7:0] ebf, input logic [7:0] etg, input logic eat,
                        input logic eflt);
        exp_t e;
        e.tag = tag; e.st = st; e.af = eaf; e.bf = ebf; e.tgt = etg;
        e.at = eat; e.flt = eflt; e.rdy = !drv_brake && !cancel;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk(e.tag, "state",     int'(state),        int'(e.st));
                chk(e.tag, "af",        int'(af),           int'(e.af));
                chk(e.tag, "bf",        int'(bf),           int'(e.bf));
                chk(e.tag, "target",    int'(target),       int'(e.tgt));
                chk(e.tag, "at_speed",  int'(at_speed),     int'(e.at));
                chk(e.tag, "engaged",   int'(engaged),      int'(e.st != 2'd0));
                chk(e.tag, "fault",     int'(fault),        int'(e.flt));
                chk(e.tag, "set_ready", int'(sif.set_ready), int'(e.rdy));
            end
        end
    end

    localparam logic [1:0] S_IDLE = 2'd0, S_ACCEL = 2'd1, S_CRUISE = 2'd2, S_BRAKE = 2'd3;

    initial begin
        rst = 1'b1; speed = 8'd0; cancel = 1'b0; drv_brake = 1'b0; drv_bf = 8'd0;
        sif.set_valid = 1'b0; sif.set_speed = 8'd0;
        @(negedge clk);

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            speed = 8'($urandom); cancel = 1'($urandom); drv_brake = 1'($urandom);
            drv_bf = 8'($urandom); sif.set_valid = 1'($urandom); sif.set_speed = 8'($urandom);
            tick("reset", S_IDLE, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        end
        rst = 1'b0; cancel = 1'b0; drv_brake = 1'b0; drv_bf = 8'd0; sif.set_valid = 1'b0;

        // accel ramp
        speed = 8'd50; sif.set_valid = 1'b1; sif.set_speed = 8'd100;
        tick("set100", S_ACCEL, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        sif.set_valid = 1'b0;
        for (int i = 1; i <= 22; i++)
            tick("accel", S_ACCEL, (i * 10 > 200) ? 8'd200 : 8'(i * 10), 8'd0, 8'd100, 1'b0, 1'b0);

        // settle into cruise, hold, then overshoot
        speed = 8'd97;
        tick("to_cruise", S_CRUISE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            tick("hold", S_CRUISE, 8'd0, 8'd0, 8'd100, (i >= 4), 1'b0);
        speed = 8'd105;
        tick("overshoot", S_BRAKE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        tick("brake1", S_BRAKE, 8'd0, 8'd10, 8'd100, 1'b0, 1'b0);

        // brake ramp from a fresh set
        speed = 8'd120; sif.set_valid = 1'b1; sif.set_speed = 8'd100;
        tick("set_brake", S_BRAKE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        sif.set_valid = 1'b0;
        for (int i = 1; i <= 3; i++)
            tick("bramp", S_BRAKE, 8'd0, 8'(i * 10), 8'd100, 1'b0, 1'b0);
        speed = 8'd104;
        tick("brake_exit", S_CRUISE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);

        // driver brake overrides accel, target kept
        speed = 8'd50; sif.set_valid = 1'b1; sif.set_speed = 8'd100;
        tick("set_acc", S_ACCEL, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        sif.set_valid = 1'b0;
        tick("acc1", S_ACCEL, 8'd10, 8'd0, 8'd100, 1'b0, 1'b0);
        tick("acc2", S_ACCEL, 8'd20, 8'd0, 8'd100, 1'b0, 1'b0);
        drv_brake = 1'b1; drv_bf = 8'd55;
        tick("drv_brake", S_IDLE, 8'd0, 8'd55, 8'd100, 1'b0, 1'b0);
        drv_brake = 1'b0; drv_bf = 8'd0;
        tick("post_brake", S_IDLE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);

        // cancel blocks a simultaneous set
        cancel = 1'b1; sif.set_valid = 1'b1; sif.set_speed = 8'd150;
        tick("cancel_set", S_IDLE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        cancel = 1'b0; sif.set_valid = 1'b0;
        tick("idle_hold", S_IDLE, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);

        // band saturation at both ends of the 8-bit range
        speed = 8'd0; sif.set_valid = 1'b1; sif.set_speed = 8'd2;
        tick("lo_sat", S_CRUISE, 8'd0, 8'd0, 8'd2, 1'b0, 1'b0);
        speed = 8'd255; sif.set_speed = 8'd253;
        tick("hi_sat", S_CRUISE, 8'd0, 8'd0, 8'd253, 1'b0, 1'b0);
        speed = 8'd255; sif.set_speed = 8'd250;
        tick("hi_out", S_BRAKE, 8'd0, 8'd0, 8'd250, 1'b0, 1'b0);
        sif.set_valid = 1'b0;

        // watchdog on a stuck accel
        speed = 8'd50; sif.set_valid = 1'b1; sif.set_speed = 8'd100;
        tick("wdt_set", S_ACCEL, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        sif.set_valid = 1'b0;
        for (int i = 1; i <= 68; i++) begin
`ifdef CRUISE_WDT_EN
            if (i < 64)
                tick("wdt_run", S_ACCEL, (i * 10 > 200) ? 8'd200 : 8'(i * 10), 8'd0, 8'd100, 1'b0, 1'b0);
            else
                tick("wdt_trip", S_IDLE, 8'd0, 8'd0, 8'd100, 1'b0, (i == 64));
`else
            tick("no_wdt", S_ACCEL, (i * 10 > 200) ? 8'd200 : 8'(i * 10), 8'd0, 8'd100, 1'b0, 1'b0);
`endif
        end

        // reset beats driver brake
        sif.set_valid = 1'b1; sif.set_speed = 8'd100;
        tick("reengage", S_ACCEL, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
        sif.set_valid = 1'b0;
        rst = 1'b1; drv_brake = 1'b1; drv_bf = 8'd77;
        tick("rst_vs_brake", S_IDLE, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0; drv_brake = 1'b0; drv_bf = 8'd0;

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cruise_sched.md
# cruise_sched

Closed-loop scheduler that sequences accelerator-force (`af`) and brake-force (`bf`) commands into the speed datapath so that the measured speed converges on a driver-programmed target. It sits between the driver controls (set/cancel/brake pedal) and the speed datapath, and arbitrates between the driver's brake request and its own cruise commands. The driver brake always wins. All command outputs are registered and ramp-limited so the datapath never sees a step larger than `STEP`.

## Interface
- `STEP`, 10: per-cycle `af`/`bf` ramp increment.
- `HYST`, 4: half-width of the in-band deadband around the target.
- `HOLD_CYCLES`, 4: consecutive in-band cycles before `at_speed` asserts.
- `AF_MAX`, 200: `af` saturation ceiling.
- `BF_MAX`, 200: `bf` saturation ceiling for cruise braking.
- `WDT_CYCLES`, 64: watchdog limit (used only with `CRUISE_WDT_EN`).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `speed`  in  8  measured speed from the datapath, unsigned.
- `set_valid`  in  1  request to load `set_speed` as the target.
- `set_speed`  in  8  new target speed.
- `set_ready`  out  1  combinational: `!drv_brake && !cancel`.
- `cancel`  in  1  driver cancel; disengages cruise.
- `drv_brake`  in  1  driver brake pedal active.
- `drv_bf`  in  8  driver brake force.
- `af`  out  8  accelerator-force command (registered).
- `bf`  out  8  brake-force command (registered).
- `state`  out  2  encoding: IDLE=0, ACCEL=1, CRUISE=2, BRAKE=3.
- `engaged`  out  1  high when `state != IDLE`.
- `at_speed`  out  1  held in band for `HOLD_CYCLES` cycles.
- `target`  out  8  latched target speed.
- `fault`  out  1  one-cycle watchdog pulse.

## Operation
- Band limits use 8-bit saturating arithmetic:
  - `lo = max(target-HYST, 0)`
  - `hi = min(target+HYST, 255)`
  - in band: `lo <= speed <= hi`
- Band evaluation `next_from_band`:
  - `speed < lo` → ACCEL
  - `speed > hi` → BRAKE
  - otherwise → CRUISE
- Per-cycle priority, highest first, evaluated in every state:
  1. **`drv_brake`**: state → IDLE, `af`←0, `bf`←`drv_bf`, `at_speed`←0. The target is kept.
  2. **`cancel`**: state → IDLE, `af`←0, `bf`←0, `at_speed`←0.
  3. **`set_valid` (accepted when `set_ready`)**: `target`←`set_speed`. Next state = `next_from_band`, evaluated against the new target. `af`/`bf` restart from 0, the hold counter clears, and the watchdog counter clears.
  4. **State behaviour**, below.
- IDLE: `af`=`bf`=0. Stays in IDLE until a set request is accepted.
- ACCEL:
  - `af` ← `min(af+STEP, AF_MAX)`; `bf`←0.
  - If `speed >= lo`: go to CRUISE with `af`←0 on that edge.
- BRAKE:
  - `bf` ← `min(bf+STEP, BF_MAX)`; `af`←0.
  - If `speed <= hi`: go to CRUISE with `bf`←0 on that edge.
- CRUISE:
  - `af`=`bf`=0.
  - Hold counter increments while in band, saturating at `HOLD_CYCLES`. `at_speed`=1 once the counter equals `HOLD_CYCLES`.
  - Leaving the band goes to `next_from_band` and clears both the counter and `at_speed`.
- Width rules:
  - All ramp sums are computed 9 bits wide before saturating, so `af`/`bf` never wrap.
  - `drv_bf` passes through unclamped.

## Timing
- Every registered output updates on the edge after the inputs are sampled: 1-cycle latency from `speed`, `set_valid`, `cancel` or `drv_brake`.
- First `af` in ACCEL is `STEP`, one cycle after the set is accepted. `af` reaches `AF_MAX` after `ceil(AF_MAX/STEP)` cycles.
- Hold behaviour: `at_speed` rises on the `HOLD_CYCLES`-th consecutive CRUISE cycle spent in band.
- Reset values:
  - `state`=IDLE
  - `af`=`bf`=`target`=0
  - `engaged`=`at_speed`=`fault`=0
  - all internal counters = 0
- `rst` overrides everything, including `drv_brake`. An asserted `rst` in any state lands in IDLE on the next edge.
- `set_valid` with `set_ready` low is ignored; it is not queued.

## Configuration
- `CRUISE_WDT_EN` defined:
  - A counter runs while in ACCEL or BRAKE and clears on any other state or on an accepted set.
  - On reaching `WDT_CYCLES`: state → IDLE, `af`=`bf`=0, and `fault` pulses high for exactly one cycle.
  - `drv_brake` and `cancel` keep their priority over the watchdog.
- `CRUISE_WDT_EN` undefined: no watchdog logic; `fault` is tied to 0.

## Test plan
All scenarios use default parameters.
- **Reset.** Hold `rst` for 2 cycles with random inputs → `state`=0, `af`=`bf`=`target`=0, `engaged`=`at_speed`=`fault`=0.
- **Accel ramp.** `set_speed`=100, `speed` held at 50 → ACCEL next cycle. `af` = 10, 20, …, reaches 200 on cycle 20 and holds there; `bf`=0 throughout.
- **Settle to cruise.** In ACCEL, `speed`→97 → next cycle CRUISE with `af`=0. `at_speed`=1 after 4 in-band cycles. Then `speed`→105 → BRAKE with `bf`=10, and `at_speed`=0.
- **Brake ramp.** Target 100, `speed`=120 → BRAKE with `bf`=10, 20, 30. Then `speed`→104 → CRUISE with `bf`=0.
- **Priority.**
  - In ACCEL, `drv_brake`=1 with `drv_bf`=55 → next cycle IDLE, `af`=0, `bf`=55, `engaged`=0, `target` unchanged.
  - `cancel` and `set_valid` in the same cycle → `set_ready`=0, target not loaded, IDLE.
- **Watchdog (`CRUISE_WDT_EN` defined).** Target 100, `speed` stuck at 50 → after 64 ACCEL cycles, one-cycle `fault` pulse and IDLE. Without the macro, ACCEL persists and `fault` stays 0.
